// File: rtl/chip_mem_responder.sv
// Chip load/store burst responder backed by a local buffer RAM, with a host preload/readback port; OOB_CHECK_EN adds an out-of-range guard.
// Latency: request accepted in the cycle it is seen; loads take 2 cycles per beat (fetch + beat); stores take 1 cycle per beat; host reads return 1 cycle after host_re.
// Backpressure: each beat holds until chip_rready_or_wvalid; host strobes outside IDLE are dropped.
module chip_mem_responder #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    enable,
    input  logic                    chip_axvalid,
    input  logic [ADDR_W+LEN_W-1:0] chip_axaddr_and_axlen,
    input  logic                    chip_load_or_store,
    input  logic                    chip_store_byte4,
    output logic                    chip_axready,
    output logic                    chip_rvalid_or_wready,
    input  logic                    chip_rready_or_wvalid,
    input  logic [DATA_W-1:0]       chip_data_in,
    output logic [DATA_W-1:0]       chip_data_out,
    output logic                    chip_data_oe,
    output logic                    chip_done,
    input  logic                    host_we,
    input  logic                    host_re,
    input  logic [ADDR_W-1:0]       host_addr,
    input  logic [DATA_W-1:0]       host_wdata,
    output logic [DATA_W-1:0]       host_rdata,
    output logic                    host_rvalid,
    output logic                    busy,
    output logic                    err_sticky,
    input  logic                    err_clr
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_FETCH, S_RD_BEAT, S_WR_BEAT, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_cnt;
    logic              byte4_q;
    logic              oob_q;

    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              host_sel;
    logic              accept;
    logic              beat_hs;
    logic              wr_hs;
    logic              last_beat;

    assign req_addr  = chip_axaddr_and_axlen[ADDR_W+LEN_W-1:LEN_W];
    assign req_len   = chip_axaddr_and_axlen[LEN_W-1:0];
    // Host strobes win over a chip request in the same IDLE cycle.
    assign host_sel  = (state == S_IDLE) && (host_we || host_re);
    assign accept    = (state == S_IDLE) && !(host_we || host_re) && enable && chip_axvalid;
    assign beat_hs   = chip_rready_or_wvalid && ((state == S_RD_BEAT) || (state == S_WR_BEAT));
    assign wr_hs     = chip_rready_or_wvalid && (state == S_WR_BEAT);
    assign last_beat = (beat_cnt == len_q);

`ifdef OOB_CHECK_EN
    logic [ADDR_W:0] req_end;
    logic            req_oob;

    assign req_end = {1'b0, req_addr} + {{(ADDR_W+1-LEN_W){1'b0}}, req_len};
    assign req_oob = req_end[ADDR_W];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            oob_q      <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            if (accept) oob_q <= req_oob;
            if (accept && req_oob) err_sticky <= 1'b1;
            else if (err_clr)      err_sticky <= 1'b0;
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign oob_q          = 1'b0;
    assign err_sticky     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (accept) state_nxt = chip_load_or_store ? S_WR_BEAT : S_RD_FETCH;
            S_RD_FETCH: state_nxt = S_RD_BEAT;
            S_RD_BEAT:  if (beat_hs) state_nxt = last_beat ? S_DONE : S_RD_FETCH;
            S_WR_BEAT:  if (beat_hs && last_beat) state_nxt = S_DONE;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        chip_axready          = accept;
        chip_rvalid_or_wready = (state == S_RD_BEAT) || (state == S_WR_BEAT);
        chip_data_oe          = (state == S_RD_BEAT);
        chip_done             = (state == S_DONE);
        busy                  = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur_addr      <= '0;
            len_q         <= '0;
            beat_cnt      <= '0;
            byte4_q       <= 1'b0;
            chip_data_out <= '0;
            host_rdata    <= '0;
            host_rvalid   <= 1'b0;
        end else begin
            host_rvalid <= host_sel && host_re;
            if (host_sel && host_re) host_rdata <= mem[host_addr];
            if (accept) begin
                cur_addr <= req_addr;
                len_q    <= req_len;
                beat_cnt <= '0;
                byte4_q  <= chip_store_byte4;
            end else if (beat_hs) begin
                cur_addr <= cur_addr + ADDR_W'(1);
                beat_cnt <= beat_cnt + LEN_W'(1);
            end
            // Load data is captured during the fetch cycle and held through the beat.
            if (state == S_RD_FETCH) chip_data_out <= oob_q ? '0 : mem[cur_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (host_sel && host_we) begin
            mem[host_addr] <= host_wdata;
        end else if (wr_hs && !oob_q) begin
            if (byte4_q) mem[cur_addr][31:0] <= chip_data_in[31:0];
            else         mem[cur_addr]       <= chip_data_in;
        end
    end

endmodule
